mem_arbiter: RTL and testbench

- Shares the single physical-memory burst port between the instruction-cache and data-cache miss paths of the 5-stage RV32I pipeline.
- Each requester presents one cache-line transaction at a time; the arbiter picks one, holds its address/data stable to memory until completion, returns the line, then releases.
- Simultaneous requests are granted round-robin, so neither an instruction-fetch miss nor a load/store miss can starve.
- Sits between the icache/dcache miss controllers and the pmem interface.

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the icache, dcache and pmem signals around mem_arbiter.
//   master : arbiter view (drives pmem strobes/address/wdata, cache rdata/resp)
//   slave  : environment view (caches + physical memory)
//   icache : i_read, i_address -> ; <- i_rdata, i_resp
//   dcache : d_read, d_write, d_address, d_wdata -> ; <- d_rdata, d_resp
//   pmem   : <- pmem_read, pmem_write, pmem_address, pmem_wdata ; pmem_rdata, pmem_resp ->
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) ();
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pmem line-burst port between icache and dcache misses.
// One transaction at a time, round-robin on simultaneous requests.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; aborts any transaction in flight
//   bus   : mem_arbiter_if.master (icache, dcache and pmem signal groups)
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, SERV_I, SERV_D, RESP_I, RESP_D} state_t;

    state_t            r_state;
    logic              r_last_d;      // 1: last grant went to the dcache
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_op_wr;
    logic              r_pmem_read;
    logic              r_pmem_write;
    logic [LINE_W-1:0] r_i_rdata;
    logic [LINE_W-1:0] r_d_rdata;
    logic              r_i_resp;
    logic              r_d_resp;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_i;

    assign w_i_req   = bus.i_read;
    assign w_d_req   = bus.d_read | bus.d_write;
    // On a tie the side that did not win last time goes; after reset that is I.
    assign w_grant_i = w_i_req & (~w_d_req | r_last_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_d     <= 1'b1;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_op_wr      <= 1'b0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_i_resp     <= 1'b0;
            r_d_resp     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_i_req || w_d_req) begin
                        // Everything memory sees comes from these captures, so the
                        // requesters may change their inputs during service.
                        r_addr   <= w_grant_i ? bus.i_address : bus.d_address;
                        r_wdata  <= bus.d_wdata;
                        r_last_d <= ~w_grant_i;
                        if (w_grant_i) begin
                            r_op_wr     <= 1'b0;
                            r_pmem_read <= 1'b1;
                            r_state     <= SERV_I;
                        end else begin
                            // Read and write together: the writeback wins.
                            r_op_wr      <= bus.d_write;
                            r_pmem_write <= bus.d_write;
                            r_pmem_read  <= ~bus.d_write;
                            r_state      <= SERV_D;
                        end
                    end
                end
                SERV_I: begin
                    if (bus.pmem_resp) begin
                        r_i_rdata   <= bus.pmem_rdata;
                        r_pmem_read <= 1'b0;
                        r_i_resp    <= 1'b1;
                        r_state     <= RESP_I;
                    end
                end
                SERV_D: begin
                    if (bus.pmem_resp) begin
                        if (!r_op_wr) r_d_rdata <= bus.pmem_rdata;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        r_d_resp     <= 1'b1;
                        r_state      <= RESP_D;
                    end
                end
                // The IDLE cycle after a response gives the requester time to drop
                // its request so it is not served twice.
                RESP_I: begin
                    r_i_resp <= 1'b0;
                    r_state  <= IDLE;
                end
                RESP_D: begin
                    r_d_resp <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.pmem_read    = r_pmem_read;
    assign bus.pmem_write   = r_pmem_write;
    assign bus.pmem_address = r_addr;
    assign bus.pmem_wdata   = r_wdata;
    assign bus.i_rdata      = r_i_rdata;
    assign bus.d_rdata      = r_d_rdata;
    assign bus.i_resp       = r_i_resp;
    assign bus.d_resp       = r_d_resp;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level model of the arbitration rules.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();
    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // memory responder controls
    int          mem_lat   = 0;
    bit          mem_rand  = 0;
    bit          mem_fixed = 0;
    logic [LW-1:0] mem_data = '0;
    bit          force_resp = 0;
    int          cnt = 0;
    int          cur_lat = 0;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW/32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Memory: answers a strobe after cur_lat extra cycles; rdata is garbage
    // except in the pmem_resp cycle.
    always begin
        @(posedge clk);
        #1;
        if (bus.pmem_read || bus.pmem_write) begin
            if (cnt >= cur_lat) begin
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = mem_fixed ? mem_data : rand_line();
                cnt = 0;
                cur_lat = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
            end else begin
                bus.pmem_resp  = force_resp;
                bus.pmem_rdata = rand_line();
                cnt++;
            end
        end else begin
            cnt = 0;
            cur_lat = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
            bus.pmem_resp  = force_resp;
            bus.pmem_rdata = rand_line();
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_read = 0; bus.d_read = 0; bus.d_write = 0;
        bus.i_address = '0; bus.d_address = '0; bus.d_wdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++;
        if ({bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata,
             bus.i_rdata, bus.d_rdata, bus.i_resp, bus.d_resp} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rd %b wr %b addr %h iresp %b dresp %b, required all 0",
                     bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.i_resp, bus.d_resp);
        end
    endtask

    task automatic test_reset_mid_service();
        int seen = 0;
        int bad = 0;
        mem_rand = 0; mem_lat = 20;
        @(negedge clk);
        bus.d_write = 1; bus.d_address = 32'h0000_4000; bus.d_wdata = rand_line();
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            if (bus.pmem_write) seen = 1;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL rstmid_setup: pmem_write never rose, required 1"); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.pmem_write !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_strobe: pmem_write %b, required 0 without a clock edge", bus.pmem_write);
        end
        n_tests++;
        if ({bus.pmem_read, bus.pmem_address, bus.pmem_wdata, bus.i_rdata, bus.d_rdata,
             bus.i_resp, bus.d_resp} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: addr %h rd %b dresp %b, required all 0",
                               bus.pmem_address, bus.pmem_read, bus.d_resp);
        end
        bus.d_write = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.d_resp || bus.pmem_write || bus.pmem_read) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL rstmid_after: %0d cycles with resp/strobe, required 0", bad); end
    endtask

    task automatic test_single_i();
        int rd = 0, wr = 0, bad_addr = 0, got = 0, resp_ok = 0, dr = 0, first = -1;
        bit prev_presp = 0;
        mem_rand = 0; mem_lat = 4; mem_fixed = 1; mem_data = {32{8'hA5}};
        @(negedge clk);
        bus.i_read = 1; bus.i_address = 32'h0000_1000;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.pmem_read) begin
                rd++;
                if (first < 0) first = c;
                if (bus.pmem_address !== 32'h0000_1000) bad_addr++;
            end
            if (bus.pmem_write) wr++;
            if (bus.d_resp) dr++;
            if (bus.i_resp) begin
                got++;
                if (prev_presp) resp_ok++;
                bus.i_read = 0;
            end
            prev_presp = bus.pmem_resp;
        end
        mem_fixed = 0;
        n_tests++; if (first != 0) begin n_fail++; $display("FAIL i_grant_lat: strobe at cycle %0d, required 0", first); end
        n_tests++; if (rd != 5) begin n_fail++; $display("FAIL i_strobe_len: %0d cycles, required 5", rd); end
        n_tests++; if (bad_addr != 0 || wr != 0) begin n_fail++; $display("FAIL i_addr: %0d bad addr, %0d write cycles, required 0/0", bad_addr, wr); end
        n_tests++; if (got != 1 || resp_ok != 1) begin n_fail++; $display("FAIL i_resp: %0d pulses (%0d after pmem_resp), required 1/1", got, resp_ok); end
        n_tests++; if (bus.i_rdata !== {32{8'hA5}}) begin n_fail++; $display("FAIL i_rdata: %h, required a5..a5", bus.i_rdata); end
        n_tests++; if (dr != 0) begin n_fail++; $display("FAIL i_no_dresp: %0d d_resp pulses, required 0", dr); end
    endtask

    task automatic test_d_write();
        logic [LW-1:0] wd = {8{32'h1234_5678}};
        int wr = 0, rd = 0, bad = 0, got = 0, ir = 0;
        mem_rand = 0; mem_lat = 3;
        @(negedge clk);
        bus.d_write = 1; bus.d_address = 32'h0000_2040; bus.d_wdata = wd;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.pmem_write) begin
                wr++;
                if (bus.pmem_address !== 32'h0000_2040 || bus.pmem_wdata !== wd) bad++;
                bus.d_address = 32'hDEAD_0000; bus.d_wdata = ~wd;
            end
            if (bus.pmem_read) rd++;
            if (bus.i_resp) ir++;
            if (bus.d_resp) begin got++; bus.d_write = 0; end
        end
        n_tests++; if (wr != 4 || bad != 0) begin n_fail++; $display("FAIL dw_hold: %0d write cycles, %0d bad addr/wdata, required 4/0", wr, bad); end
        n_tests++; if (rd != 0 || ir != 0) begin n_fail++; $display("FAIL dw_noread: %0d read cycles %0d i_resp, required 0/0", rd, ir); end
        n_tests++; if (got != 1) begin n_fail++; $display("FAIL dw_resp: %0d d_resp pulses, required 1", got); end
    endtask

    task automatic test_tie();
        bit order[4];
        int grants = 0, nresp = 0, both = 0, gap = -1, resp_c = -1;
        bit prev_st = 0, st;
        do_reset();
        mem_rand = 1;
        @(negedge clk);
        bus.i_read = 1; bus.i_address = 32'h0000_0100;
        bus.d_read = 1; bus.d_address = 32'h8000_0200;
        for (int c = 0; c < 80 && nresp < 4; c++) begin
            @(negedge clk);
            st = bus.pmem_read | bus.pmem_write;
            if (st && !prev_st && grants < 4) begin
                order[grants] = (bus.pmem_address == 32'h0000_0100);
                if (grants == 1) gap = c - resp_c;
                grants++;
            end
            if (bus.i_resp && bus.d_resp) both++;
            if (bus.i_resp || bus.d_resp) begin
                nresp++;
                if (nresp == 1) resp_c = c;
                if (nresp == 4) begin bus.i_read = 0; bus.d_read = 0; end
            end
            prev_st = st;
        end
        bus.i_read = 0; bus.d_read = 0;
        n_tests++; if (grants != 4) begin n_fail++; $display("FAIL tie_count: %0d grants, required 4", grants); end
        for (int g = 0; g < 4; g++) begin
            n_tests++;
            if (order[g] !== ((g % 2) == 0)) begin
                n_fail++; $display("FAIL tie_order[%0d]: got %s, required %s", g,
                                   order[g] ? "I" : "D", ((g % 2) == 0) ? "I" : "D");
            end
        end
        n_tests++; if (gap != 2) begin n_fail++; $display("FAIL tie_gap: %0d cycles resp->next strobe, required 2", gap); end
        n_tests++; if (both != 0) begin n_fail++; $display("FAIL tie_both_resp: %0d cycles, required 0", both); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_rw_both();
        logic [LW-1:0] hold = bus.d_rdata;
        int wr = 0, rd = 0, got = 0;
        mem_rand = 0; mem_lat = 1;
        @(negedge clk);
        bus.d_read = 1; bus.d_write = 1; bus.d_address = 32'h0000_3000; bus.d_wdata = rand_line();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.pmem_write) wr++;
            if (bus.pmem_read) rd++;
            if (bus.d_resp) begin got++; bus.d_read = 0; bus.d_write = 0; end
        end
        n_tests++; if (wr != 2 || rd != 0) begin n_fail++; $display("FAIL rw_write_wins: wr %0d rd %0d cycles, required 2/0", wr, rd); end
        n_tests++; if (got != 1) begin n_fail++; $display("FAIL rw_resp: %0d pulses, required 1", got); end
        n_tests++; if (bus.d_rdata !== hold) begin n_fail++; $display("FAIL rw_rdata: %h, required unchanged %h", bus.d_rdata, hold); end
    endtask

    task automatic test_spurious();
        logic [LW-1:0] ih = bus.i_rdata, dh = bus.d_rdata;
        logic [LW-1:0] nd = rand_line();
        int bad = 0, got = 0;
        @(negedge clk);
        force_resp = 1;
        repeat (2) @(negedge clk);
        force_resp = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.i_resp || bus.d_resp || bus.pmem_read || bus.pmem_write) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL spur_idle: %0d cycles with resp/strobe, required 0", bad); end
        n_tests++; if (bus.i_rdata !== ih || bus.d_rdata !== dh) begin n_fail++; $display("FAIL spur_rdata: i %h d %h, required unchanged", bus.i_rdata, bus.d_rdata); end
        mem_rand = 0; mem_lat = 0; mem_fixed = 1; mem_data = nd;
        bus.i_read = 1; bus.i_address = 32'h0000_0500;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.i_resp) begin got++; bus.i_read = 0; end
        end
        mem_fixed = 0;
        n_tests++; if (got != 1 || bus.i_rdata !== nd) begin n_fail++; $display("FAIL spur_next_read: %0d resp, rdata %h, required 1, %h", got, bus.i_rdata, nd); end
    endtask

    // Model: a grant is decided from the requests visible in the cycle before
    // the strobe appears; ties alternate, starting with I after reset.
    task automatic test_random();
        bit i_act = 0, d_act = 0, d_wr = 0, pi = 0, pd = 0, prev_st = 0, last_d = 1, cur_i = 0;
        bit st, exp_i, ok;
        logic [AW-1:0] ia = '0, da = '0;
        logic [LW-1:0] dwd = '0, i_exp = '0, d_exp = '0, d_keep = '0, dx;
        int done_i = 0, done_d = 0, op;
        do_reset();
        mem_rand = 1; mem_fixed = 0;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            st = bus.pmem_read | bus.pmem_write;
            if (st && !prev_st) begin
                exp_i = pi && (!pd || last_d);
                last_d = !exp_i; cur_i = exp_i;
                if (exp_i) ok = bus.pmem_read && !bus.pmem_write && bus.pmem_address == ia;
                else ok = (bus.pmem_write == d_wr) && (bus.pmem_read == !d_wr) &&
                          bus.pmem_address == da && (!d_wr || bus.pmem_wdata == dwd);
                n_tests++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL rand_grant c%0d: rd %b wr %b addr %h, required side %s addr %h",
                             c, bus.pmem_read, bus.pmem_write, bus.pmem_address, exp_i ? "I" : "D", exp_i ? ia : da);
                end
            end
            if (st && bus.pmem_resp) begin
                if (cur_i) i_exp = bus.pmem_rdata;
                else if (!d_wr) d_exp = bus.pmem_rdata;
            end
            if (bus.i_resp) begin
                n_tests++;
                if (!i_act || !cur_i || bus.d_resp || bus.i_rdata !== i_exp) begin
                    n_fail++; $display("FAIL rand_iresp c%0d: act %b rdata %h, required 1 %h", c, i_act, bus.i_rdata, i_exp);
                end
                i_act = 0; bus.i_read = 0; done_i++;
            end
            if (bus.d_resp) begin
                dx = d_wr ? d_keep : d_exp;
                n_tests++;
                if (!d_act || cur_i || bus.d_rdata !== dx) begin
                    n_fail++; $display("FAIL rand_dresp c%0d: act %b rdata %h, required 1 %h", c, d_act, bus.d_rdata, dx);
                end
                if (!d_wr) d_keep = d_exp;
                d_act = 0; bus.d_read = 0; bus.d_write = 0; done_d++;
            end
            if (c < 640) begin
                if (!i_act && $urandom_range(0, 2) == 0) begin
                    i_act = 1; ia = {1'b0, 31'($urandom)};
                    bus.i_read = 1; bus.i_address = ia;
                end
                if (!d_act && $urandom_range(0, 2) == 0) begin
                    d_act = 1; da = {1'b1, 31'($urandom)}; dwd = rand_line();
                    op = $urandom_range(0, 2);
                    d_wr = (op != 0);
                    bus.d_read = (op != 1); bus.d_write = (op != 0);
                    bus.d_address = da; bus.d_wdata = dwd;
                end
            end
            pi = bus.i_read; pd = bus.d_read | bus.d_write; prev_st = st;
        end
        n_tests++;
        if (i_act || d_act || done_i == 0 || done_d == 0) begin
            n_fail++; $display("FAIL rand_drain: pending i %b d %b, done %0d/%0d, required none pending and both served",
                               i_act, d_act, done_i, done_d);
        end
    endtask

    initial begin
        bus.i_read = 0; bus.d_read = 0; bus.d_write = 0;
        bus.i_address = '0; bus.d_address = '0; bus.d_wdata = '0;
        test_reset();
        test_reset_mid_service();
        test_single_i();
        test_d_write();
        test_tie();
        test_rw_both();
        test_spurious();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
